inst_mem_responder: RTL and testbench

//  AXI4 read-only responder (AR/R channels) that serves the core's instruction-fetch master from an on-chip word memory.
//  A side load port fills the memory while the core is held (EXEC low).

---
 rtl/inst_mem_responder_pkg.sv | 11 +
 rtl/inst_mem_responder_bram.sv | 25 ++
 rtl/inst_mem_responder.sv | 126 ++++++++++++
 tb/tb_inst_mem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_responder_pkg.sv
// Shared AXI encodings and FSM state type for the instruction-memory responder.
package inst_mem_responder_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;
endpackage

// File: rtl/inst_mem_responder_bram.sv
// Word memory: one synchronous read port with enable (registered output) and one write port.
module inst_mem_bram #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);
  logic [DW-1:0] mem [2**AW];

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Same-cycle read of a word being written returns the old value.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/inst_mem_responder.sv
// AXI4 read-only responder serving instruction fetch from on-chip memory, with a side load port.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEM_WORDS_LOG2   = 12
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic                          LD_WE,
  input  logic [C_MEM_WORDS_LOG2-1:0]   LD_ADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] LD_DATA
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int ML = C_MEM_WORDS_LOG2;

  state_t                state_q, state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] id_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [2:0]            size_q;
  logic [AW-1:0]         addr_q;
  logic [8:0]            cnt_q;
  logic                  rvalid_q, rlast_q, err_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] bram_q;

  logic          ar_hs, r_done, remain, fetch;
  logic [AW-1:0] f_addr, f_addr_nxt;
  logic [1:0]    f_burst;
  logic [2:0]    f_size;
  logic          f_last, f_err;
  logic          unused_lsb;

  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_done = rvalid_q && S_AXI_RREADY && rlast_q;
  // cnt_q is the index of the next beat to fetch; beats remain while it is <= len
  assign remain = cnt_q <= {1'b0, len_q};
  assign fetch  = ar_hs || (state_q == ST_BURST && remain && (!rvalid_q || S_AXI_RREADY));

  // On the AR handshake the first beat is fetched straight from the AR channel.
  assign f_addr     = ar_hs ? S_AXI_ARADDR  : addr_q;
  assign f_burst    = ar_hs ? S_AXI_ARBURST : burst_q;
  assign f_size     = ar_hs ? S_AXI_ARSIZE  : size_q;
  assign f_last     = ar_hs ? (S_AXI_ARLEN == 8'd0) : (cnt_q[7:0] == len_q);
  assign f_err      = (|f_addr[AW-1:ML+2]) || f_burst[1] || (f_size != SIZE_4B);
  assign f_addr_nxt = (f_burst == BURST_INCR) ? f_addr + AW'(4) : f_addr;
  assign unused_lsb = ^f_addr[1:0];

  always_comb begin
    state_d       = state_q;
    S_AXI_ARREADY = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by reset so ARREADY reads low while held in reset.
        S_AXI_ARREADY = RST;
        if (ar_hs) state_d = ST_BURST;
      end
      ST_BURST: if (r_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      len_q    <= '0;
      burst_q  <= BURST_FIXED;
      size_q   <= SIZE_4B;
      addr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        id_q    <= S_AXI_ARID;
        len_q   <= S_AXI_ARLEN;
        burst_q <= S_AXI_ARBURST;
        size_q  <= S_AXI_ARSIZE;
      end
      if (fetch) begin
        addr_q   <= f_addr_nxt;
        cnt_q    <= ar_hs ? 9'd1 : cnt_q + 9'd1;
        rlast_q  <= f_last;
        err_q    <= f_err;
        rvalid_q <= 1'b1;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  inst_mem_bram #(.AW(ML), .DW(C_S_AXI_DATA_WIDTH)) u_bram (
    .clk   (CLK),
    .rst_n (RST),
    .re    (fetch),
    .raddr (f_addr[ML+1:2]),
    .rdata (bram_q),
    .we    (LD_WE),
    .waddr (LD_ADDR),
    .wdata (LD_DATA)
  );

  assign S_AXI_RID    = id_q;
  assign S_AXI_RDATA  = err_q ? '0 : bram_q;
  assign S_AXI_RRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RLAST  = rlast_q;
  assign S_AXI_RVALID = rvalid_q;
endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomized self-checking bench for inst_mem_responder against a per-beat reference model.
module tb_inst_mem_responder;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [0:0]  S_AXI_ARID = '0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic [7:0]  S_AXI_ARLEN = '0;
  logic [2:0]  S_AXI_ARSIZE = 3'b010;
  logic [1:0]  S_AXI_ARBURST = 2'b01;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [0:0]  S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        LD_WE = 1'b0;
  logic [11:0] LD_ADDR = '0;
  logic [31:0] LD_DATA = '0;

  inst_mem_responder dut (
    .CLK(CLK), .RST(RST),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA)
  );

  always #5 CLK = ~CLK;

  logic [31:0] model [4096];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_word(input logic [11:0] idx, input logic [31:0] data);
    LD_ADDR = idx; LD_DATA = data; LD_WE = 1'b1;
    tick();
    LD_WE = 1'b0;
    model[idx] = data;
  endtask

  // rmode: 0 RREADY always high, 1 alternating 1,0,1,0..., 2 random
  task automatic run_txn(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input int rmode,
                         input bit ld_en, input logic [11:0] ld_idx, input logic [31:0] ld_data);
    logic [31:0] ed[$];
    logic [1:0]  er[$];
    logic [31:0] a, hd;
    bit          e, stalled, rr;
    int          k, cyc, to;
    for (int i = 0; i <= int'(len); i++) begin
      a = (burst == 2'b01) ? addr + 32'(4 * i) : addr;
      e = (a[31:14] != 0) || burst[1] || (size != 3'b010);
      ed.push_back(e ? 32'h0 : model[a[13:2]]);
      er.push_back(e ? 2'b10 : 2'b00);
    end
    if (ld_en) model[ld_idx] = ld_data;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
    S_AXI_ARBURST = burst; S_AXI_ARSIZE = size; S_AXI_ARVALID = 1'b1;
    LD_WE = ld_en; LD_ADDR = ld_idx; LD_DATA = ld_data;
    to = 0;
    while (!S_AXI_ARREADY && to < 50) begin tick(); LD_WE = 1'b0; to++; end
    if (!S_AXI_ARREADY) begin
      chk("arready_timeout", 32'(S_AXI_ARREADY), 32'd1);
      S_AXI_ARVALID = 1'b0; LD_WE = 1'b0;
      return;
    end
    tick();
    S_AXI_ARVALID = 1'b0; LD_WE = 1'b0;
    chk("first_rvalid", 32'(S_AXI_RVALID), 32'd1);
    k = 0; cyc = 0; stalled = 0; hd = '0;
    while (k <= int'(len) && cyc < 2000) begin
      chk("rvalid_cont", 32'(S_AXI_RVALID), 32'd1);
      if (stalled) chk("hold_data", S_AXI_RDATA, hd);
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2) == 0;
        default: rr = $urandom_range(1, 0) == 1;
      endcase
      S_AXI_RREADY = rr;
      if (S_AXI_RVALID && rr) begin
        chk("rdata", S_AXI_RDATA, ed[k]);
        chk("rresp", 32'(S_AXI_RRESP), 32'(er[k]));
        chk("rid",   32'(S_AXI_RID), 32'(id));
        chk("rlast", 32'(S_AXI_RLAST), 32'(k == int'(len)));
        k++;
        stalled = 0;
      end else if (S_AXI_RVALID) begin
        stalled = 1;
        hd = S_AXI_RDATA;
      end
      tick();
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
    if (k <= int'(len)) chk("beat_timeout", 32'(k), 32'(len) + 1);
    chk("arready_after", 32'(S_AXI_ARREADY), 32'd1);
    chk("rvalid_after", 32'(S_AXI_RVALID), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rb;
    logic [2:0]  rs;
    int          r;
    repeat (3) tick();
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_rvalid",  32'(S_AXI_RVALID), 32'd0);
    chk("rst_rlast",   32'(S_AXI_RLAST), 32'd0);
    chk("rst_rdata",   S_AXI_RDATA, 32'd0);
    chk("rst_rid",     32'(S_AXI_RID), 32'd0);
    chk("rst_rresp",   32'(S_AXI_RRESP), 32'd0);
    RST = 1'b1;
    #1;
    chk("rel_arready", 32'(S_AXI_ARREADY), 32'd1);

    for (int i = 0; i < 4096; i++) load_word(12'(i), $urandom);
    load_word(12'd0, 32'h00000013);
    load_word(12'd1, 32'h00100093);
    load_word(12'd2, 32'h00200113);
    load_word(12'd3, 32'h00300193);
    load_word(12'd4, 32'hDEADBEEF);

    run_txn(1'b0, 32'h0, 8'd0, 2'b01, 3'b010, 0, 0, '0, '0);
    run_txn(1'b0, 32'h4, 8'd3, 2'b01, 3'b010, 0, 0, '0, '0);
    run_txn(1'b0, 32'h4, 8'd3, 2'b01, 3'b010, 1, 0, '0, '0);
    run_txn(1'b0, 32'h8, 8'd2, 2'b00, 3'b010, 0, 0, '0, '0);
    run_txn(1'b1, 32'h4000, 8'd1, 2'b01, 3'b010, 0, 0, '0, '0);
    run_txn(1'b0, 32'h0, 8'd1, 2'b10, 3'b010, 0, 0, '0, '0);
    run_txn(1'b0, 32'h0, 8'd0, 2'b01, 3'b001, 0, 0, '0, '0);
    run_txn(1'b1, 32'hFFFF_FFF8, 8'd3, 2'b01, 3'b010, 2, 0, '0, '0);
    run_txn(1'b0, 32'h3FF8, 8'd3, 2'b01, 3'b010, 0, 0, '0, '0);
    run_txn(1'b0, 32'h13, 8'd0, 2'b01, 3'b010, 0, 1, 12'd4, 32'h1234_5678);
    run_txn(1'b0, 32'h10, 8'd0, 2'b01, 3'b010, 0, 0, '0, '0);

    // Reset mid-burst, then a normal single read
    S_AXI_ARID = 1'b0; S_AXI_ARADDR = 32'h0; S_AXI_ARLEN = 8'd3;
    S_AXI_ARBURST = 2'b01; S_AXI_ARSIZE = 3'b010; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    tick();
    chk("mid_beat2_valid", 32'(S_AXI_RVALID), 32'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("mid_rst_rlast",  32'(S_AXI_RLAST), 32'd0);
    S_AXI_RREADY = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    chk("mid_rel_arready", 32'(S_AXI_ARREADY), 32'd1);
    run_txn(1'b0, 32'hC, 8'd0, 2'b01, 3'b010, 0, 0, '0, '0);

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(2, 0)) load_word(12'($urandom), $urandom);
      r = $urandom_range(7, 0);
      if (r == 0)      ra = $urandom;
      else if (r == 1) ra = 32'h3FC0 + 32'($urandom_range(63, 0));
      else             ra = 32'($urandom_range(16383, 0));
      r = $urandom_range(7, 0);
      rb = (r < 3 || r == 7) ? 2'b01 : (r < 5) ? 2'b00 : (r == 5) ? 2'b10 : 2'b11;
      rs = ($urandom_range(7, 0) == 0) ? 3'($urandom) : 3'b010;
      run_txn(1'($urandom), ra, 8'($urandom_range(15, 0)), rb, rs,
              int'($urandom_range(2, 0)), 0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
